// File: rtl/mem_initiator_pkg.sv
// Shared types and constants for the MU0 memory-bus initiator and its benches.
// IDLE/ACCESS/RESP encodings are fixed so traces stay readable across builds.
package mem_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // What the memory drives on dataOut when it is not serving a read.
  localparam logic [15:0] MEM_IDLE_PATTERN = 16'hBFBF;
  localparam logic [15:0] WR_RSP_DATA      = 16'h0000;
  localparam int          WAIT_W           = 4;

endpackage

// File: rtl/mem_initiator_sat_ctr.sv
// 16-bit event counter that sticks at all-ones; a clear beats a same-cycle increment.
module mem_initiator_sat_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_initiator.sv
// MU0 memory-bus master: one request -> one memRq burst of 1+WAIT_CYCLES cycles -> one response.
// Response held until rsp_ready; MEM_INITIATOR_STATS_EN adds saturating read/write counters.
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              memRq,
  output logic              readNotWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_INITIATOR_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  state_e              state_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic                mem_rq_q;
  logic                rnw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rsp_vld_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   rdata_d;
  logic                access_done;

  assign access_done = (state_q == ACCESS) && (cnt_q == '0);
  assign rdata_d     = rnw_q ? mem_rdata : DATA_W'(WR_RSP_DATA);

  // All memory-side outputs come straight from flops, so readNotWrite cannot
  // glitch while memRq is high and everything drops together on leaving ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_rq_q  <= 1'b0;
      rnw_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_vld_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q  <= ACCESS;
            cnt_q    <= WAIT_INIT;
            mem_rq_q <= 1'b1;
            rnw_q    <= ~req_write;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q   <= RESP;
            mem_rq_q  <= 1'b0;
            rnw_q     <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_vld_q <= 1'b1;
            rdata_q   <= rdata_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q   <= IDLE;
            rsp_vld_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_vld_q;
  assign rsp_rdata    = rdata_q;
  assign memRq        = mem_rq_q;
  assign readNotWrite = rnw_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

`ifdef MEM_INITIATOR_STATS_EN
  mem_initiator_sat_ctr u_rd_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (stats_clr),
    .inc_i   (access_done && rnw_q),
    .count_o (rd_count)
  );

  mem_initiator_sat_ctr u_wr_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (stats_clr),
    .inc_i   (access_done && !rnw_q),
    .count_o (wr_count)
  );
`endif

endmodule
